// File: rtl/mem_pixel_array_sync.sv
// Simple dual-port RGB444 pixel frame buffer.
// One write port (system side) and one read port (display scan) on a single clock.
// The read path has a fixed 2-cycle latency: rdaddress is registered, then the array
// output is registered, so q never has a combinational path from any input.
// Reads that collide with a write on the same edge return the old word.
// Out-of-range reads return 0, because scan logic issues them during blanking.
// Out-of-range writes are dropped.

module mem_pixel_array_sync #(
   parameter int unsigned DATA_W = 12,
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned DEPTH  = 64000
) (
   input  logic              main_clk,
   input  logic              rst,
   input  logic              wren,
   input  logic [ADDR_W-1:0] wraddress,
   input  logic [DATA_W-1:0] data,
   input  logic [ADDR_W-1:0] rdaddress,
   output logic [DATA_W-1:0] q
);

   // Frame storage. Power-up contents are zero; reset leaves it untouched.
   logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] q_r;
   logic              wr_in_range;
   logic              rd_in_range;

   // Unsigned range checks against DEPTH; no wraparound or modulo on addresses.
   always_comb begin
      wr_in_range = 1'b0;
      rd_in_range = 1'b0;
      wr_in_range = (32'(wraddress) < DEPTH);
      rd_in_range = (32'(addr_r) < DEPTH);
   end

   // Write port: out-of-range writes and writes during reset are ignored.
   always_ff @(posedge main_clk) begin
      if (!rst && wren && wr_in_range) begin
         mem[wraddress] <= data;
      end
   end

   // Read stage 1: capture the scan address every cycle.
   always_ff @(posedge main_clk) begin
      if (rst) begin
         addr_r <= '0;
      end else begin
         addr_r <= rdaddress;
      end
   end

   // Read stage 2: the array is read with the old contents on a same-edge write.
   always_ff @(posedge main_clk) begin
      if (rst) begin
         q_r <= '0;
      end else if (rd_in_range) begin
         q_r <= mem[addr_r];
      end else begin
         q_r <= '0;
      end
   end

   assign q = q_r;

endmodule

// File: tb/tb_mem_pixel_array_sync.sv
// Directed self-checking bench for mem_pixel_array_sync.
// Inputs change and outputs are sampled 1 time unit after each rising edge.

module tb_mem_pixel_array_sync;

   localparam int unsigned DataW = 12;
   localparam int unsigned AddrW = 16;
   localparam int unsigned Depth = 64000;

   logic             main_clk;
   logic             rst;
   logic             wren;
   logic [AddrW-1:0] wraddress;
   logic [DataW-1:0] data;
   logic [AddrW-1:0] rdaddress;
   logic [DataW-1:0] q;

   int n_vec;
   int n_bad;

   // Stream stimulus table: addresses and expected read words.
   int             sa [8];
   logic [DataW-1:0] se [8];

   mem_pixel_array_sync #(
      .DATA_W (DataW),
      .ADDR_W (AddrW),
      .DEPTH  (Depth)
   ) dut (
      .main_clk  (main_clk),
      .rst       (rst),
      .wren      (wren),
      .wraddress (wraddress),
      .data      (data),
      .rdaddress (rdaddress),
      .q         (q)
   );

   initial begin
      main_clk = 1'b0;
      forever #5 main_clk = ~main_clk;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout, want finish (%0d vectors)", n_vec);
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [DataW-1:0] obs,
                           input logic [DataW-1:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge main_clk);
      #1;
   endtask

   task automatic wr(input int addr, input logic [DataW-1:0] d);
      wren      = 1'b1;
      wraddress = AddrW'(addr);
      data      = d;
      tick();
      wren      = 1'b0;
   endtask

   // Issue sa[0..n-1] on consecutive cycles; q after edge i holds sa[i-1]'s word.
   task automatic stream(input string tag, input int n);
      for (int i = 0; i <= n; i++) begin
         rdaddress = (i < n) ? AddrW'(sa[i]) : '0;
         tick();
         if (i >= 1) check_eq($sformatf("%s[%0d]", tag, i - 1), q, se[i - 1]);
      end
   endtask

   function automatic logic [DataW-1:0] sweep_word(input int a);
      logic [31:0] av;
      av = a;
      return (a < int'(Depth)) ? av[DataW-1:0] : '0;
   endfunction

   // Sequential read from start after the full-frame sweep; optional 1-cycle reset at rst_at.
   task automatic seq_read(input string tag, input int start, input int n, input int rst_at);
      for (int i = 0; i <= n; i++) begin
         rdaddress = AddrW'(start + i);
         rst       = (i == rst_at);
         tick();
         if (i == rst_at) begin
            check_eq($sformatf("%s_rst", tag), q, '0);
         end else if (rst_at >= 0 && i == rst_at + 1) begin
            // Stage 1 was cleared to address 0, which holds 0 after the sweep.
            check_eq($sformatf("%s_post", tag), q, sweep_word(0));
         end else if (i >= 1) begin
            check_eq($sformatf("%s@%0d", tag, start + i - 1), q, sweep_word(start + i - 1));
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      n_vec     = 0;
      n_bad     = 0;
      rst       = 1'b1;
      wren      = 1'b0;
      wraddress = '0;
      data      = '0;
      rdaddress = 16'd7;

      // Reset holds q at zero for any read address.
      for (int i = 0; i < 3; i++) begin
         rdaddress = AddrW'(7 + i * 1000);
         tick();
         check_eq($sformatf("reset_q%0d", i), q, '0);
      end
      rst = 1'b0;

      // Power-up contents are zero.
      rdaddress = 16'd6;
      tick();
      tick();
      check_eq("powerup_zero", q, '0);

      // Preload, then reset with a write attempt: contents survive, write ignored.
      wr(5, 12'hABC);
      rst       = 1'b1;
      wren      = 1'b1;
      wraddress = 16'd5;
      data      = 12'h555;
      rdaddress = 16'd5;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq($sformatf("reset2_q%0d", i), q, '0);
      end
      rst  = 1'b0;
      wren = 1'b0;
      tick();
      tick();
      check_eq("preload_kept", q, 12'hABC);

      // Write then stream-read at one word per clock, including the top address.
      wr(0, 12'h0F0);
      wr(1, 12'h00F);
      wr(63999, 12'hF00);
      wr(64000, 12'h123);
      sa[0] = 0;     se[0] = 12'h0F0;
      sa[1] = 1;     se[1] = 12'h00F;
      sa[2] = 63999; se[2] = 12'hF00;
      sa[3] = 64000; se[3] = 12'h000;
      sa[4] = 65535; se[4] = 12'h000;
      sa[5] = 0;     se[5] = 12'h0F0;
      sa[6] = 5;     se[6] = 12'hABC;
      stream("stream", 7);

      // Collision: same-edge write returns old data, the next read sees the new word.
      wr(10, 12'h111);
      rdaddress = 16'd10;
      tick();
      rdaddress = 16'd10;
      wren      = 1'b1;
      wraddress = 16'd10;
      data      = 12'h222;
      tick();
      check_eq("collide_old", q, 12'h111);
      wren      = 1'b0;
      rdaddress = 16'd0;
      tick();
      check_eq("collide_new", q, 12'h222);

      // Full-frame sweep write.
      for (int a = 0; a < int'(Depth); a++) begin
         wren      = 1'b1;
         wraddress = AddrW'(a);
         data      = sweep_word(a);
         tick();
      end
      wren = 1'b0;

      seq_read("sweep_top", 63990, 14, -1);
      seq_read("sweep_max", 65529, 6, -1);
      seq_read("sweep_mid", 0, 1000, 500);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
